add_accum_unit: RTL and testbench

ADD_ACCUM_UNIT -- requirements
Module: add_accum_unit

---
 rtl/add_accum_unit.sv | 91 +++++++++
 tb/tb_add_accum_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/add_accum_unit.sv
// Add/subtract/accumulate unit with a single valid/ready output register.
// It offers optional unsigned saturation and a count of accepted operations.
module add_accum_unit #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SAT_EN = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  logic             accept;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   acc_sum;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] nxt_result;
  logic             nxt_flag;
  logic             nxt_acc_load;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  assign add_sum = {1'b0, a} + {1'b0, b};
  assign acc_sum = {1'b0, acc} + {1'b0, a};
  assign diff    = a - b;
  assign borrow  = (a < b);

  // Result/flag selection; saturation clamps to all-ones on carry, zero on borrow.
  always_comb begin
    nxt_result   = '0;
    nxt_flag     = 1'b0;
    nxt_acc_load = 1'b0;
    case (op)
      OP_ADD: begin
        nxt_flag   = add_sum[WIDTH];
        nxt_result = (SAT_EN != 0 && add_sum[WIDTH]) ? ALL_ONES : add_sum[WIDTH-1:0];
      end
      OP_SUB: begin
        nxt_flag   = borrow;
        nxt_result = (SAT_EN != 0 && borrow) ? '0 : diff;
      end
      OP_ACC: begin
        nxt_flag     = acc_sum[WIDTH];
        nxt_result   = (SAT_EN != 0 && acc_sum[WIDTH]) ? ALL_ONES : acc_sum[WIDTH-1:0];
        nxt_acc_load = 1'b1;
      end
      OP_LOAD: begin
        nxt_result   = a;
        nxt_acc_load = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag      <= 1'b0;
      acc       <= '0;
      op_count  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= nxt_result;
      flag      <= nxt_flag;
      op_count  <= op_count + CNT_W'(1);
      if (nxt_acc_load) acc <= nxt_result;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_add_accum_unit.sv
// Directed bench: saturating, wrapping and small-counter instances share one stimulus stream.
module tb_add_accum_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [1:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_ready;

  logic        s_in_ready, s_out_valid, s_flag;
  logic [7:0]  s_result, s_acc;
  logic [15:0] s_count;
  logic        w_in_ready, w_out_valid, w_flag;
  logic [7:0]  w_result, w_acc;
  logic [15:0] w_count;
  logic        c_in_ready, c_out_valid, c_flag;
  logic [7:0]  c_result, c_acc;
  logic [3:0]  c_count;

  int vecs = 0;
  int errs = 0;

  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

  always #5 clk = ~clk;

  add_accum_unit #(.WIDTH(8), .SAT_EN(1), .CNT_W(16)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .op(op), .a(a), .b(b),
    .out_valid(s_out_valid), .out_ready(out_ready), .result(s_result), .flag(s_flag),
    .acc(s_acc), .op_count(s_count));

  add_accum_unit #(.WIDTH(8), .SAT_EN(0), .CNT_W(16)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .op(op), .a(a), .b(b),
    .out_valid(w_out_valid), .out_ready(out_ready), .result(w_result), .flag(w_flag),
    .acc(w_acc), .op_count(w_count));

  add_accum_unit #(.WIDTH(8), .SAT_EN(1), .CNT_W(4)) u_cnt (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready), .op(op), .a(a), .b(b),
    .out_valid(c_out_valid), .out_ready(out_ready), .result(c_result), .flag(c_flag),
    .acc(c_acc), .op_count(c_count));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, then settle just after the edge.
  task automatic step(input logic [1:0] o, input logic [7:0] aa, input logic [7:0] bb,
                      input logic v, input logic r);
    op = o; a = aa; b = bb; in_valid = v; out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = ADD; a = '0; b = '0; out_ready = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(s_out_valid), 0);
    check("rst_result",    32'(s_result), 0);
    check("rst_flag",      32'(s_flag), 0);
    check("rst_acc",       32'(s_acc), 0);
    check("rst_count",     32'(s_count), 0);
    check("rst_in_ready",  32'(s_in_ready), 1);

    step(ADD, 8'd200, 8'd100, 1'b1, 1'b1);
    check("sat_add_result", 32'(s_result), 255);
    check("sat_add_flag",   32'(s_flag), 1);
    check("sat_add_valid",  32'(s_out_valid), 1);
    check("sat_add_count",  32'(s_count), 1);
    check("wrap_add_result", 32'(w_result), 44);
    check("wrap_add_flag",   32'(w_flag), 1);

    step(SUB, 8'd5, 8'd10, 1'b1, 1'b1);
    check("wrap_sub_result", 32'(w_result), 251);
    check("wrap_sub_flag",   32'(w_flag), 1);
    check("sat_sub_result",  32'(s_result), 0);
    check("sat_sub_flag",    32'(s_flag), 1);

    step(SUB, 8'd10, 8'd5, 1'b1, 1'b1);
    check("sub_nb_result", 32'(s_result), 5);
    check("sub_nb_flag",   32'(s_flag), 0);

    step(LOAD, 8'd250, 8'd99, 1'b1, 1'b1);
    check("load_result", 32'(s_result), 250);
    check("load_flag",   32'(s_flag), 0);
    check("load_acc",    32'(s_acc), 250);

    step(ACC, 8'd3, 8'd77, 1'b1, 1'b1);
    check("acc3_result", 32'(s_result), 253);
    check("acc3_flag",   32'(s_flag), 0);
    check("acc3_acc",    32'(s_acc), 253);

    step(ADD, 8'd1, 8'd2, 1'b1, 1'b1);
    check("mid_add_result", 32'(s_result), 3);
    check("mid_add_acc",    32'(s_acc), 253);

    step(ACC, 8'd5, 8'd0, 1'b1, 1'b1);
    check("acc5_result", 32'(s_result), 255);
    check("acc5_flag",   32'(s_flag), 1);
    check("acc5_acc",    32'(s_acc), 255);
    check("wrap_acc5_result", 32'(w_result), 2);
    check("wrap_acc5_acc",    32'(w_acc), 2);

    // Idle cycle with garbage operands must not touch state.
    step(LOAD, 8'd17, 8'd33, 1'b0, 1'b1);
    check("idle_valid", 32'(s_out_valid), 0);
    check("idle_acc",   32'(s_acc), 255);
    check("idle_count", 32'(s_count), 7);

    step(ADD, 8'd1, 8'd1, 1'b1, 1'b0);
    check("bp_first_result", 32'(s_result), 2);
    check("bp_first_valid",  32'(s_out_valid), 1);
    for (int i = 0; i < 3; i++) begin
      step(ADD, 8'd3, 8'd3, 1'b1, 1'b0);
      check("bp_in_ready", 32'(s_in_ready), 0);
      check("bp_result",   32'(s_result), 2);
      check("bp_valid",    32'(s_out_valid), 1);
      check("bp_count",    32'(s_count), 8);
    end
    step(ADD, 8'd3, 8'd3, 1'b1, 1'b1);
    check("bp_drain_result", 32'(s_result), 6);
    check("bp_drain_valid",  32'(s_out_valid), 1);
    check("bp_drain_count",  32'(s_count), 9);

    step(ADD, 8'd0, 8'd0, 1'b0, 1'b1);
    check("drain_clear_valid", 32'(s_out_valid), 0);

    step(LOAD, 8'd77, 8'd0, 1'b1, 1'b1);
    check("pre_rst_acc", 32'(s_acc), 77);
    step(ADD, 8'd4, 8'd4, 1'b1, 1'b0);
    check("pre_rst_valid", 32'(s_out_valid), 1);
    rst = 1'b1;
    step(ADD, 8'd9, 8'd9, 1'b1, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_valid",    32'(s_out_valid), 0);
    check("midrst_acc",      32'(s_acc), 0);
    check("midrst_count",    32'(s_count), 0);
    check("midrst_result",   32'(s_result), 0);
    check("midrst_in_ready", 32'(s_in_ready), 1);

    // Seventeen back-to-back accepts wrap the 4-bit counter.
    for (int i = 0; i < 17; i++) begin
      op = ADD; a = 8'd1; b = 8'd1; in_valid = 1'b1; out_ready = 1'b1;
      #1;
      check("wrap_no_stall", 32'(c_in_ready), 1);
      @(posedge clk); #1;
      check("wrap_cnt", 32'(c_count), 32'((i + 1) % 16));
    end
    check("wrap_cnt_final", 32'(c_count), 1);
    check("wide_cnt_final", 32'(s_count), 17);

    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
